// File: rtl/cpu_pkg.sv
// Shared types for the simple CPU: opcode type, halt opcode and sequencer states.
package cpu_pkg;

    typedef logic [3:0] opcode_t;

    localparam opcode_t HALT_OP = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        EXEC,
        WAIT,
        HALT
    } seq_state_t;

endpackage

// File: rtl/instruction_sequencer.sv
// Fetches instructions from a registered ROM, splits opcode/immediate and strobes
// execute_n low for one clk per instruction at a fixed cycles-per-instruction pace.
module instruction_sequencer #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned INSTR_W     = 8,
    parameter int unsigned EXEC_CYCLES = 2,
    parameter logic [3:0]  HALT_OP     = cpu_pkg::HALT_OP
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    input  logic               step,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [3:0]         opcode,
    output logic [3:0]         imm,
    output logic               execute_n,
    output logic [ADDR_W-1:0]  pc,
    output logic               busy,
    output logic               halted
);

    import cpu_pkg::*;

    localparam int unsigned CNT_W = $clog2(EXEC_CYCLES + 1);

    seq_state_t       state;
    seq_state_t       state_nx;
    logic [CNT_W-1:0] wait_cnt;
    opcode_t          rom_op_c;

    // The ROM is addressed straight from the program counter.
    assign instr_addr = pc;

    // Next-state decode.
    always_comb begin
        state_nx = state;
        rom_op_c = opcode_t'(instr_data[INSTR_W-1 -: 4]);
        case (state)
            IDLE:    if (run || step) state_nx = FETCH;
            FETCH:   state_nx = LATCH;
            LATCH:   state_nx = (rom_op_c == HALT_OP) ? HALT : EXEC;
            EXEC:    state_nx = WAIT;
            WAIT: begin
                if (wait_cnt == CNT_W'(EXEC_CYCLES - 1)) begin
                    state_nx = run ? FETCH : IDLE;
                end
            end
            HALT:    state_nx = HALT;
            default: state_nx = IDLE;
        endcase
    end

    // State, program counter and registered outputs; flags follow the next state
    // so they line up with the state they describe.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            pc        <= '0;
            opcode    <= '0;
            imm       <= '0;
            execute_n <= 1'b1;
            busy      <= 1'b0;
            halted    <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nx;
            execute_n <= (state_nx != EXEC);
            busy      <= state_nx inside {FETCH, LATCH, EXEC, WAIT};
            halted    <= (state_nx == HALT);

            // A halt word never reaches the Control_Unit.
            if (state == LATCH && state_nx == EXEC) begin
                opcode <= rom_op_c;
                imm    <= instr_data[3:0];
            end

            if (state == EXEC) begin
                pc <= pc + ADDR_W'(1);
            end

            if (state == WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench for instruction_sequencer: a per-instruction timing model predicts
// every execute_n strobe (cycle, opcode, imm, pc) and is compared with what the DUT issues.
module tb_instruction_sequencer;

    localparam int unsigned EC  = 2;
    localparam int unsigned CPI = 3 + EC;

    typedef struct {
        int         cyc;
        logic [3:0] op;
        logic [3:0] imm;
        logic [3:0] pc;
    } ev_t;

    logic       clk;
    logic       rstn;
    logic       run;
    logic       step;
    logic [3:0] instr_addr;
    logic [7:0] instr_data;
    logic [3:0] opcode;
    logic [3:0] imm;
    logic       execute_n;
    logic [3:0] pc;
    logic       busy;
    logic       halted;

    logic [7:0] rom [16];
    int         cyc      = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    bit         mon_en   = 1'b0;
    ev_t        obs_q [$];
    ev_t        exp_q [$];

    instruction_sequencer #(
        .ADDR_W     (4),
        .INSTR_W    (8),
        .EXEC_CYCLES(EC),
        .HALT_OP    (4'hF)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .run       (run),
        .step      (step),
        .instr_addr(instr_addr),
        .instr_data(instr_data),
        .opcode    (opcode),
        .imm       (imm),
        .execute_n (execute_n),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered program ROM: data valid one clk after the address.
    always @(posedge clk) instr_data <= rom[instr_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Record strobes and check the always-true relations between the flags.
    always @(negedge clk) begin
        if (mon_en) begin
            if (execute_n === 1'b0) obs_q.push_back('{cyc, opcode, imm, pc});
            chk("busy_halted_exclusive", 32'(busy & halted), 32'd0);
            chk("strobe_outside_busy", 32'(!execute_n && (!busy || halted)), 32'd0);
        end
    end

    // Instruction k of a burst started in cycle c strobes at c+3+k*CPI; a halt word ends it.
    function automatic int expect_run(input int c, input int start, input int max_n);
        for (int k = 0; k < max_n; k++) begin
            int a = (start + k) % 16;
            if (rom[a][7:4] == 4'hF) return k;
            exp_q.push_back('{c + 3 + int'(CPI) * k, rom[a][7:4], rom[a][3:0], 4'(a)});
        end
        return -1;
    endfunction

    task automatic compare_strobes(input string tag);
        chk({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_cyc"}, 32'(obs_q[i].cyc), 32'(exp_q[i].cyc));
            chk({tag, "_op"},  32'(obs_q[i].op),  32'(exp_q[i].op));
            chk({tag, "_imm"}, 32'(obs_q[i].imm), 32'(exp_q[i].imm));
            chk({tag, "_pc"},  32'(obs_q[i].pc),  32'(exp_q[i].pc));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic fill_rand(input int halt_at);
        for (int i = 0; i < 16; i++) begin
            rom[i] = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
        end
        if (halt_at >= 0) rom[halt_at] = {4'hF, 4'($urandom_range(0, 15))};
    endtask

    task automatic do_reset();
        @(negedge clk);
        run  = 1'b0;
        step = 1'b0;
        rstn = 1'b0;
        #2;
        rstn = 1'b1;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_halt_run(input string tag, input int h);
        int c;
        do_reset();
        @(negedge clk);
        run = 1'b1;
        c   = cyc;
        chk({tag, "_halt_index"}, 32'(expect_run(c, 0, 16)), 32'(h));
        wait_to(c + 3 + int'(CPI) * h + 3);
        chk({tag, "_halted"}, 32'(halted), 32'd1);
        chk({tag, "_pc"}, 32'(pc), 32'(h));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_opcode_held"}, 32'(opcode), 32'(rom[h-1][7:4]));
        compare_strobes(tag);
        // Keys are ignored once halted.
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (20) @(negedge clk);
        chk({tag, "_still_halted"}, 32'(halted), 32'd1);
        chk({tag, "_pc_after_keys"}, 32'(pc), 32'(h));
        compare_strobes({tag, "_after"});
        run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int c2;
        int d;
        int r;
        rstn = 1'b1;
        run  = 1'b0;
        step = 1'b0;
        fill_rand(-1);

        // Asynchronous reset window.
        #15 rstn = 1'b0;
        #5;
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_imm", 32'(imm), 32'd0);
        chk("rst_execute_n", 32'(execute_n), 32'd1);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr_addr", 32'(instr_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        #5 rstn = 1'b1;
        mon_en = 1'b1;

        // Single step of 8'h3A.
        fill_rand(-1);
        rom[0] = 8'h3A;
        do_reset();
        @(negedge clk);
        step = 1'b1;
        c    = cyc;
        @(negedge clk);
        step = 1'b0;
        void'(expect_run(c, 0, 1));
        wait_to(c + 5);
        chk("step_busy_last_wait", 32'(busy), 32'd1);
        wait_to(c + 6);
        chk("step_busy_done", 32'(busy), 32'd0);
        chk("step_pc", 32'(pc), 32'd1);
        chk("step_opcode", 32'(opcode), 32'h3);
        chk("step_imm", 32'(imm), 32'hA);
        compare_strobes("step");

        // Directed program ending in a halt word, then random halt positions.
        fill_rand(-1);
        rom[0] = 8'h10;
        rom[1] = 8'h21;
        rom[2] = 8'h32;
        rom[3] = 8'hF0;
        check_halt_run("prog", 3);
        for (int i = 0; i < 3; i++) begin
            d = int'($urandom_range(2, 9));
            fill_rand(d);
            check_halt_run("rand_prog", d);
        end

        // Program counter wrap over 17 instructions.
        for (int i = 0; i < 16; i++) rom[i] = 8'h11;
        do_reset();
        @(negedge clk);
        run = 1'b1;
        c   = cyc;
        void'(expect_run(c, 0, 17));
        wait_to(c + 1 + int'(CPI) * 16);
        chk("wrap_fetch_addr", 32'(instr_addr), 32'd0);
        wait_to(c + 3 + int'(CPI) * 16);
        run = 1'b0;
        wait_to(c + 3 + int'(CPI) * 16 + 10);
        chk("wrap_busy", 32'(busy), 32'd0);
        chk("wrap_pc", 32'(pc), 32'd1);
        compare_strobes("wrap");

        // Run dropped in WAIT with a step pulsed during EXEC, then one step from IDLE.
        for (int i = 0; i < 3; i++) begin
            d = int'($urandom_range(1, 4));
            fill_rand(-1);
            do_reset();
            @(negedge clk);
            run = 1'b1;
            c   = cyc;
            void'(expect_run(c, 0, d));
            wait_to(c + 3 + int'(CPI) * (d - 1));
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            run  = 1'b0;
            wait_to(c + 3 + int'(CPI) * d + 5);
            chk("drop_busy", 32'(busy), 32'd0);
            chk("drop_pc", 32'(pc), 32'(d));
            compare_strobes("drop");
            @(negedge clk);
            step = 1'b1;
            c2   = cyc;
            @(negedge clk);
            step = 1'b0;
            void'(expect_run(c2, d, 1));
            wait_to(c2 + 8);
            chk("drop_step_pc", 32'(pc), 32'(d + 1));
            chk("drop_step_busy", 32'(busy), 32'd0);
            compare_strobes("drop_step");
        end

        // Reset while execute_n is low.
        fill_rand(-1);
        do_reset();
        @(negedge clk);
        run = 1'b1;
        c   = cyc;
        r   = int'($urandom_range(0, 2));
        void'(expect_run(c, 0, r + 1));
        wait_to(c + 3 + int'(CPI) * r);
        #2;
        chk("mid_exec_strobe", 32'(execute_n), 32'd0);
        rstn = 1'b0;
        run  = 1'b0;
        #1;
        chk("mid_exec_rst_execute_n", 32'(execute_n), 32'd1);
        chk("mid_exec_rst_pc", 32'(pc), 32'd0);
        chk("mid_exec_rst_busy", 32'(busy), 32'd0);
        chk("mid_exec_rst_opcode", 32'(opcode), 32'd0);
        compare_strobes("mid_exec");
        @(negedge clk);
        #1 rstn = 1'b1;
        c2 = cyc;
        wait_to(c2 + 10);
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_pc", 32'(pc), 32'd0);
        compare_strobes("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
